// File: rtl/data_mem_responder.sv
// Word-organised data memory responder: valid/ready request, WAIT_CYCLES wait states, then a held response.
// Optional per-byte store enables are compiled in with DMEM_BYTE_LANE_EN.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH];

  logic        acc_fire;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic [31:0] offset;
  logic        acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0] wr_word;
  logic        unused_ok;

`ifdef DMEM_BYTE_LANE_EN
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction
`endif

  // Next state; with zero wait states the access uses the live request inputs on the accept edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_fire  = 1'b0;
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_be    = lat_be;
    case (state)
      IDLE: begin
        if (req_valid) begin
          acc_write = req_write;
          acc_addr  = req_addr;
          acc_wdata = req_wdata;
          acc_be    = req_be;
          if (WAIT_CYCLES == 0) begin
            acc_fire  = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          acc_fire  = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign offset  = acc_addr - ADDR_BASE;
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr < ADDR_BASE) ||
                   (offset[31:2] >= 30'(DEPTH));
  assign acc_idx = offset[AW+1:2];

`ifdef DMEM_BYTE_LANE_EN
  assign wr_word = lane_merge(mem[acc_idx], acc_wdata, acc_be);
`else
  assign wr_word = acc_wdata;
`endif

  assign unused_ok = ^{offset[1:0], acc_be};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (acc_fire) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Request capture for the wait-state path; data registers carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // Reset gates the write so a store cannot commit while reset is held.
  always_ff @(posedge clk) begin
    if (acc_fire && reset && acc_write && !acc_err) begin
      mem[acc_idx] <= wr_word;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus randomized traffic against an array model.
module tb_data_mem_responder;

  localparam int unsigned D1 = 64;
  localparam int unsigned W1 = 2;
  localparam logic [31:0] B1 = 32'h0000_0000;
  localparam int unsigned D2 = 16;
  localparam logic [31:0] B2 = 32'h0000_0100;
`ifdef DMEM_BYTE_LANE_EN
  localparam bit LANES = 1'b1;
`else
  localparam bit LANES = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  data_mem_responder #(.DEPTH(D1), .WAIT_CYCLES(W1), .ADDR_BASE(B1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy));

  data_mem_responder #(.DEPTH(D2), .WAIT_CYCLES(0), .ADDR_BASE(B2)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy));

  int ncmp = 0;
  int nfail = 0;
  logic [31:0] m1 [D1];
  logic [31:0] m2 [D2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input logic [31:0] base,
                                   input int unsigned depth);
    if (a % 4 != 0) return 1'b1;
    if (a < base) return 1'b1;
    return ((a - base) / 4) >= depth;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = (LANES && !be[i]) ? old_word[8*i +: 8] : new_word[8*i +: 8];
    return r;
  endfunction

  // Request inputs are junk outside IDLE; the responder must ignore them.
  task automatic scramble();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = 32'($urandom_range(0, 63)) * 4;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rd, output logic er);
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
    int          idx;
    exp_e = exp_err(a, B1, D1);
    exp_d = 32'd0;
    idx   = int'((a - B1) / 4);
    if (!exp_e) begin
      if (w) m1[idx] = merge(m1[idx], d, be);
      else   exp_d = m1[idx];
    end
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    rsp_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    scramble();
    while (rsp_valid !== 1'b1 && lat < 40) begin
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      lat++;
      @(negedge clk);
      scramble();
    end
    check("latency", 32'(lat), 32'(W1 + 1));
    check("rsp_rdata", rsp_rdata, exp_d);
    check("rsp_err", 32'(rsp_err), 32'(exp_e));
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      scramble();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, exp_d);
      check("hold_err", 32'(rsp_err), 32'(exp_e));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    logic        zw   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] za   [7] = '{32'h100, 32'h13C, 32'h100, 32'h13C, 32'h0FC, 32'h140, 32'h102};
    logic [31:0] zd   [7] = '{32'hCAFE_0001, 32'h5A5A_A5A5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'h0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0;
    z_req_be = 4'hF; z_rsp_ready = 1'b0;

    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_z_busy", 32'(z_busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    check("ld_deadbeef", rd, 32'hDEAD_BEEF);
    check("ld_deadbeef_err", 32'(er), 32'd0);

    xact(1'b0, 32'h12, 32'h0, 4'hF, 0, rd, er);
    check("misaligned_err", 32'(er), 32'd1);
    check("misaligned_rdata", rd, 32'd0);
    xact(1'b0, B1 + D1 * 4, 32'h0, 4'hF, 0, rd, er);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
    xact(1'b1, 32'h12, 32'h0BAD_0BAD, 4'hF, 0, rd, er);
    check("st_misaligned_err", 32'(er), 32'd1);

    // Long response stall; scramble keeps offering junk requests meanwhile.
    xact(1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er);
    check("stall_ld", rd, 32'hDEAD_BEEF);

    // Store whose access edge is cut off by reset must not commit.
    xact(1'b1, 32'h20, 32'h0, 4'hF, 0, rd, er);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("midop_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_req_ready", 32'(req_ready), 32'd1);
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rsp_err", 32'(rsp_err), 32'd0);
    check("async_rsp_rdata", rsp_rdata, 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    xact(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
    check("reset_drops_store", rd, 32'd0);

    xact(1'b1, 32'h30, 32'h1111_1111, 4'hF, 0, rd, er);
    xact(1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
    check("lane_st_err", 32'(er), 32'd0);
    xact(1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
    check("lane_ld", rd, LANES ? 32'h11BB_11DD : 32'hAABB_CCDD);
    xact(1'b1, 32'h30, 32'h7777_7777, 4'b0000, 0, rd, er);
    check("be0_err", 32'(er), 32'd0);
    xact(1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);

    for (int i = 0; i < int'(D1); i++)
      xact(1'b1, B1 + 32'(i) * 4, $urandom, 4'hF, 0, rd, er);
    for (int i = 0; i < 120; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 7);
      if (r <= 5)      a = B1 + 32'($urandom_range(0, D1 - 1)) * 4;
      else if (r == 6) a = B1 + 32'($urandom_range(0, D1 - 1)) * 4 + 32'($urandom_range(1, 3));
      else             a = B1 + 32'($urandom_range(D1, 1 << 20)) * 4;
      xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2), rd, er);
    end

    // Zero-wait instance: rsp_ready held high, one response every two cycles.
    for (int i = 0; i < 7; i++) begin
      logic [31:0] exp_d;
      logic        exp_e;
      int          idx;
      exp_e = exp_err(za[i], B2, D2);
      exp_d = 32'd0;
      idx   = int'((za[i] - B2) / 4);
      if (!exp_e) begin
        if (zw[i]) m2[idx] = zd[i];
        else       exp_d = m2[idx];
      end
      @(negedge clk);
      check("z_idle_ready", 32'(z_req_ready), 32'd1);
      check("z_idle_busy", 32'(z_busy), 32'd0);
      z_req_valid = 1'b1; z_req_write = zw[i]; z_req_addr = za[i]; z_req_wdata = zd[i];
      z_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("z_rsp_valid", 32'(z_rsp_valid), 32'd1);
      check("z_busy", 32'(z_busy), 32'd1);
      check("z_req_ready", 32'(z_req_ready), 32'd0);
      check("z_rdata", z_rsp_rdata, exp_d);
      check("z_err", 32'(z_rsp_err), 32'(exp_e));
      @(posedge clk);
    end
    @(negedge clk);
    z_req_valid = 1'b0;
    check("z_end_valid", 32'(z_rsp_valid), 32'd0);
    check("z_end_busy", 32'(z_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
